// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned multiply / divide unit.
//
// Shift-add multiplication and restoring division, one pass through a single
// shared WIDTH+1 bit ripple-carry adder/subtractor per cycle. Latency is fixed:
// a start sampled at edge t gives a one-cycle done pulse in the cycle after
// edge t+WIDTH, regardless of operands (including divide by zero).
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset
//   start   request strobe, sampled when not busy (IDLE or FIN)
//   op      0=MUL (low product) 1=MULHU (high product) 2=DIVU 3=REMU
//   a       multiplicand / dividend
//   b       multiplier / divisor
//   flush   synchronous abort; wins over start, result is kept
//   busy    operation in progress
//   done    one-cycle pulse, result valid
//   result  selected result, held until the next operation completes

// Ripple-carry adder/subtractor. With sub=1 computes x - y as x + ~y + 1;
// cout=1 then means "no borrow" (x >= y).
module seq_muldiv_rca #(
  parameter int N = 33
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         sub,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] carry;
  logic       yb;

  always_comb begin
    carry    = '0;
    sum      = '0;
    yb       = 1'b0;
    carry[0] = sub;
    for (int unsigned i = 0; i < N; i++) begin
      yb         = y[i] ^ sub;
      sum[i]     = x[i] ^ yb ^ carry[i];
      carry[i+1] = (x[i] & yb) | (carry[i] & (x[i] ^ yb));
    end
    cout = carry[N];
  end

endmodule

module seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]    count;
  logic [1:0]       op_q;
  // opnd holds the operand that is added/subtracted each cycle:
  // the multiplicand for MUL/MULHU, the divisor for DIVU/REMU.
  logic [WIDTH-1:0] opnd;
  // hi/lo form the 2*WIDTH product register P for multiply and hold
  // remainder R (hi) and quotient Q (lo) for divide.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic             accept;
  logic             is_div;

  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   add_y;
  logic [WIDTH:0]   add_sum;
  logic             add_cout;
  logic             sub_en;

  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          accept     = 1'b1;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (count == '0) begin
          state_next = FIN;
        end
      end
      FIN: begin
        done = 1'b1;
        // A start in FIN is taken immediately so operations can run back-to-back.
        if (start) begin
          state_next = CALC;
          accept     = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (flush) begin
      state_next = IDLE;
      accept     = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Shared adder: operands come only from latched state, never the live inputs
  // ---------------------------------------------------------------------------
  assign is_div = op_q[1];

  always_comb begin
    sub_en = 1'b0;
    add_x  = {1'b0, hi};
    add_y  = '0;
    if (state == CALC) begin
      if (is_div) begin
        // T = {R, Q msb}, D = T - {0, divisor}
        sub_en = 1'b1;
        add_x  = {hi, lo[WIDTH-1]};
        add_y  = {1'b0, opnd};
      end else if (lo[0]) begin
        add_y = {1'b0, opnd};
      end
    end
  end

  seq_muldiv_rca #(
    .N(WIDTH + 1)
  ) u_rca (
    .x    (add_x),
    .y    (add_y),
    .sub  (sub_en),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    if (is_div) begin
      // Restoring step: keep D when there was no borrow, otherwise keep T.
      hi_next = add_cout ? add_sum[WIDTH-1:0] : add_x[WIDTH-1:0];
      lo_next = {lo[WIDTH-2:0], add_cout};
    end else begin
      // P = {S, P_lo >> 1}: the WIDTH+1 bit sum shifts in from the top.
      hi_next = add_sum[WIDTH:1];
      lo_next = {add_sum[0], lo[WIDTH-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      op_q   <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= op;
      opnd  <= op[1] ? b : a;
      hi    <= '0;
      lo    <= op[1] ? a : b;
      count <= CW'(WIDTH - 1);
    end else if (flush) begin
      count <= '0;
    end else if (state == CALC) begin
      hi <= hi_next;
      lo <= lo_next;
      if (count == '0) begin
        // Final iteration: capture the selected half of the updated registers
        // so result is valid during the FIN (done) cycle.
        result <= op_q[0] ? hi_next : lo_next;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_muldiv.md
Name: seq_muldiv

Overview:
- Iterative unsigned multiply/divide unit that performs every add and subtract on one shared ripple-carry adder/subtractor instance.
- It uses shift-add multiplication and restoring division, one adder pass per cycle.
- It sits beside the ALU in the execute stage and serves MUL, MULHU, DIVU and REMU requests. The core stalls on busy.

Parameters:
- WIDTH, 32, operand and result width. The shared adder instance is WIDTH+1 bits wide.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request strobe. Sampled only when busy=0.
- op  in  2  operation: 0=MUL (low product), 1=MULHU (high product), 2=DIVU (quotient), 3=REMU (remainder).
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- flush  in  1  synchronous abort.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: result is valid.
- result  out  WIDTH  selected result. Held until the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, counter=0, all internal registers 0.
- States: IDLE, CALC, FIN.
- IDLE:
  - start=1 at edge t: latch op, a, b; counter=WIDTH-1; go to CALC. busy=1 from t+1.
  - start=0: stay in IDLE.
- CALC: one iteration per cycle. When counter reaches 0, go to FIN; otherwise decrement counter.
- FIN: done=1, busy=0, result registered. Next state is IDLE.
- start=1 while in FIN is accepted exactly as in IDLE; this enables back-to-back operations.
- Latency: start sampled at edge t -> done high in cycle t+WIDTH+1. Always fixed, independent of operands.
- Multiply, 2*WIDTH product register P:
  - On start: P={0, b}.
  - Per cycle: if P[0]=1, S = {0,P_hi} + {0,a}; else S = {0,P_hi}.
  - Then P = {S[WIDTH:0], P_lo[WIDTH-1:1]} (S is WIDTH+1 bits, so P is a right shift with carry-in).
  - Result: MUL = P[WIDTH-1:0]; MULHU = P[2WIDTH-1:WIDTH].
- Divide, remainder R (WIDTH bits) and quotient Q (WIDTH bits):
  - On start: R=0, Q=a.
  - Per cycle: T = {R, Q[WIDTH-1]}, WIDTH+1 bits. D = T - {0,b}, computed on the adder with subEn=1.
  - If adder cout=1 (no borrow): R=D[WIDTH-1:0] and Q={Q[WIDTH-2:0],1}.
  - Else: R=T[WIDTH-1:0] and Q={Q[WIDTH-2:0],0}.
  - Result: DIVU = Q; REMU = R.
- Divide by zero: quotient = all ones, remainder = a. The algorithm yields this naturally; no special path is permitted to change the latency.
- Adder sharing: exactly one adder instance. subEn=1 only for DIVU/REMU in CALC. Operand muxes are driven from the latched op, never from the live op input.
- Operand stability: a, b, op may change after the start edge with no effect.
- start while busy=1: ignored, with no queuing.
- flush=1 at any edge: state=IDLE, busy=0, done=0, result unchanged. The operation is discarded and no done is produced.
- flush and start together: flush wins, and start is dropped.
- rst mid-operation: immediate return to reset values. No done is produced.
- done is never high in two consecutive cycles unless a start was accepted in FIN.

Test Plan:
- MUL a=7, b=6 -> done exactly 33 cycles after the start edge; result=0x0000002A.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE. Repeat with MUL -> result=0x00000001.
- DIVU a=100, b=7 -> result=14. REMU with the same operands -> result=2. DIVU a=5, b=9 -> result=0.
- DIVU a=0x1234, b=0 -> result=0xFFFFFFFF. REMU a=0x1234, b=0 -> result=0x00001234. Both with the same 33-cycle latency.
- Start MUL 3*4, then pulse start with MUL 9*9 at cycle 10 while busy -> second request ignored; result=12. Then issue start DIVU 81/9 in the FIN cycle -> accepted; result=9 after a further 33 cycles.
- Flush at cycle 15 of MUL 5*5 -> busy drops next cycle, no done, result keeps its previous value. Separately assert rst at cycle 20 of DIVU -> busy=0 and result=0 immediately, with no done.
